leiwand_rv32_uart_tx: RTL and testbench

Wishbone slave on the core's data/instruction bus. Transmits bytes written by the core as 8N1 serial frames on one TX pin. It is selected by the SoC address decoder, like the SRAM and ROM slaves. It contains a small TX FIFO, a programmable baud divider and a bit-serialiser FSM. Its read data, ack and stall outputs are ORed with the other slaves on the shared bus.

---
 rtl/leiwand_rv32_uart_tx_pkg.sv | 26 ++
 rtl/leiwand_rv32_fifo.sv | 50 +++++
 rtl/leiwand_rv32_uart_tx.sv | 150 +++++++++++++++
 tb/tb_leiwand_rv32_uart_tx.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/leiwand_rv32_uart_tx_pkg.sv
// leiwand_rv32_uart_tx_pkg: register map, status bits and FSM states shared by the UART TX slave
package leiwand_rv32_uart_tx_pkg;

    localparam logic [31:0] UART_BASE       = 32'h1001_0000;

    localparam logic [1:0]  UART_REG_TXDATA = 2'd0;
    localparam logic [1:0]  UART_REG_STATUS = 2'd1;
    localparam logic [1:0]  UART_REG_BAUD   = 2'd2;

    localparam int          UART_STAT_BUSY  = 0;
    localparam int          UART_STAT_FULL  = 1;
    localparam int          UART_STAT_EMPTY = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_t;

    // A zero divider would never finish a bit, so it is clamped to one clock per bit.
    function automatic logic [15:0] baud_sanitize(input logic [15:0] v);
        return (v == 16'd0) ? 16'd1 : v;
    endfunction

endpackage

// File: rtl/leiwand_rv32_fifo.sv
// leiwand_rv32_fifo: small synchronous first-word-fall-through FIFO
module leiwand_rv32_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int             AW         = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = count == FULL_COUNT;
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage needs no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally; the extra count bit separates full from empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/leiwand_rv32_uart_tx.sv
// leiwand_rv32_uart_tx: Wishbone slave that serialises written bytes as 8N1 frames on tx
module leiwand_rv32_uart_tx
    import leiwand_rv32_uart_tx_pkg::*;
#(
    parameter int          MEM_WIDTH        = 32,
    parameter int          FIFO_DEPTH       = 4,
    parameter logic [15:0] DEFAULT_BAUD_DIV = 16'd434
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           wb_addr,
    input  logic [MEM_WIDTH-1:0] wb_data_in,
    output logic [MEM_WIDTH-1:0] wb_data_out,
    input  logic                 wb_we,
    input  logic                 wb_stb,
    output logic                 wb_ack,
    input  logic                 wb_cyc,
    output logic                 wb_stall,
    output logic                 tx
);

    uart_state_t          state, state_n;
    logic [7:0]           shift, shift_n;
    logic [15:0]          bit_period, bit_period_n;
    logic [15:0]          cnt, cnt_n;
    logic [2:0]           bit_idx, bit_idx_n;
    logic [15:0]          baud_div;
    logic                 req;
    logic                 accept;
    logic                 push;
    logic                 pop;
    logic                 busy;
    logic                 last;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [7:0]           fifo_dout;
    logic [MEM_WIDTH-1:0] rdata;
    logic                 unused_data_bits;

    assign unused_data_bits = ^wb_data_in[MEM_WIDTH-1:16];

    assign req      = wb_stb && wb_cyc;
    assign wb_stall = req && wb_we && (wb_addr == UART_REG_TXDATA) && fifo_full && !reset;
    assign accept   = req && !wb_stall;
    assign push     = accept && wb_we && (wb_addr == UART_REG_TXDATA);
    assign busy     = (state != ST_IDLE) || !fifo_empty;
    assign last     = cnt == bit_period - 16'd1;

    leiwand_rv32_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (wb_data_in[7:0]),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Register read mux; TXDATA and the spare slot read as zero.
    always_comb begin
        rdata = '0;
        if (wb_addr == UART_REG_STATUS) begin
            rdata[UART_STAT_BUSY]  = busy;
            rdata[UART_STAT_FULL]  = fifo_full;
            rdata[UART_STAT_EMPTY] = fifo_empty;
        end else if (wb_addr == UART_REG_BAUD) begin
            rdata[15:0] = baud_div;
        end
    end

    // One-cycle ack with read data only alongside it, plus the baud divider register.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_ack      <= 1'b0;
            wb_data_out <= '0;
            baud_div    <= DEFAULT_BAUD_DIV;
        end else begin
            wb_ack      <= accept;
            wb_data_out <= (accept && !wb_we) ? rdata : '0;
            if (accept && wb_we && wb_addr == UART_REG_BAUD)
                baud_div <= baud_sanitize(wb_data_in[15:0]);
        end
    end

    // Serialiser state; the period is captured per frame so divider writes wait for the next one.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            shift      <= '0;
            bit_period <= DEFAULT_BAUD_DIV;
            cnt        <= '0;
            bit_idx    <= '0;
        end else begin
            state      <= state_n;
            shift      <= shift_n;
            bit_period <= bit_period_n;
            cnt        <= cnt_n;
            bit_idx    <= bit_idx_n;
        end
    end

    // Next state and tx level; IDLE pops the head on the same edge it leaves for START.
    always_comb begin
        state_n      = state;
        shift_n      = shift;
        bit_period_n = bit_period;
        cnt_n        = cnt;
        bit_idx_n    = bit_idx;
        pop          = 1'b0;
        tx           = 1'b1;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop          = 1'b1;
                    shift_n      = fifo_dout;
                    bit_period_n = baud_div;
                    cnt_n        = '0;
                    state_n      = ST_START;
                end
            end
            ST_START: begin
                tx    = 1'b0;
                cnt_n = last ? 16'd0 : cnt + 16'd1;
                if (last) begin
                    bit_idx_n = '0;
                    state_n   = ST_DATA;
                end
            end
            ST_DATA: begin
                tx    = shift[0];
                cnt_n = last ? 16'd0 : cnt + 16'd1;
                if (last) begin
                    shift_n   = shift >> 1;
                    bit_idx_n = bit_idx + 3'd1;
                    state_n   = (bit_idx == 3'd7) ? ST_STOP : ST_DATA;
                end
            end
            ST_STOP: begin
                cnt_n   = last ? 16'd0 : cnt + 16'd1;
                state_n = last ? ST_IDLE : ST_STOP;
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_leiwand_rv32_uart_tx.sv
// tb_leiwand_rv32_uart_tx: directed, table-driven bench for the UART TX slave
module tb_leiwand_rv32_uart_tx;

    logic        clk;
    logic        reset;
    logic [1:0]  wb_addr;
    logic [31:0] wb_data_in;
    logic [31:0] wb_data_out;
    logic        wb_we;
    logic        wb_stb;
    logic        wb_ack;
    logic        wb_cyc;
    logic        wb_stall;
    logic        tx;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int mon_bp = 4;
    logic mon_en = 1'b1;
    logic [7:0] rx_q[$];
    int         st_q[$];

    typedef struct {
        logic [1:0]  addr;
        logic        we;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    leiwand_rv32_uart_tx dut (
        .clk         (clk),
        .reset       (reset),
        .wb_addr     (wb_addr),
        .wb_data_in  (wb_data_in),
        .wb_data_out (wb_data_out),
        .wb_we       (wb_we),
        .wb_stb      (wb_stb),
        .wb_ack      (wb_ack),
        .wb_cyc      (wb_cyc),
        .wb_stall    (wb_stall),
        .tx          (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Frame decoder: samples each bit at its first cycle using the period in force at the start bit.
    always begin
        @(negedge clk);
        if (mon_en && tx === 1'b0) begin
            int         bp;
            int         s0;
            logic [7:0] b;
            bp = mon_bp;
            s0 = cyc;
            for (int i = 0; i < 8; i++) begin
                repeat (bp) @(negedge clk);
                b[i] = tx;
            end
            repeat (bp) @(negedge clk);
            chk("stop_bit", {31'd0, tx}, 32'd1);
            rx_q.push_back(b);
            st_q.push_back(s0);
        end
    end

    task automatic bus_req(input logic [1:0] a, input logic w, input logic [31:0] d,
                           output logic [31:0] rd);
        int s;
        s = 0;
        @(negedge clk);
        wb_addr = a; wb_we = w; wb_data_in = d; wb_stb = 1'b1; wb_cyc = 1'b1;
        while (wb_stall && s < 200) begin
            @(negedge clk);
            s++;
        end
        chk("stall_bound", {31'd0, s >= 200}, 32'd0);
        @(posedge clk);
        #1;
        wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
        @(negedge clk);
        chk("ack", {31'd0, wb_ack}, 32'd1);
        rd = wb_data_out;
    endtask

    task automatic wait_rx(input int n, input int limit);
        for (int i = 0; i < limit && rx_q.size() < n; i++) @(negedge clk);
        chk("rx_count", rx_q.size(), n);
    endtask

    initial begin
        logic [31:0] rd;
        logic [7:0]  a5;
        logic        e[40];
        logic [7:0]  bytes[6];
        int          k;
        logic        acc;
        int          stall_cycles;
        int          lows;

        reset = 1'b1; wb_addr = '0; wb_data_in = '0; wb_we = 1'b0; wb_stb = 1'b0; wb_cyc = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_ack", {31'd0, wb_ack}, 32'd0);
        chk("rst_stall", {31'd0, wb_stall}, 32'd0);

        vecs[0]  = '{2'd1, 1'b0, 32'h0,         32'h4};
        vecs[1]  = '{2'd2, 1'b0, 32'h0,         32'd434};
        vecs[2]  = '{2'd0, 1'b0, 32'h0,         32'h0};
        vecs[3]  = '{2'd3, 1'b0, 32'h0,         32'h0};
        vecs[4]  = '{2'd2, 1'b1, 32'h0,         32'h0};
        vecs[5]  = '{2'd2, 1'b0, 32'h0,         32'h1};
        vecs[6]  = '{2'd2, 1'b1, 32'h1234_FFFF, 32'h0};
        vecs[7]  = '{2'd2, 1'b0, 32'h0,         32'h0000_FFFF};
        vecs[8]  = '{2'd3, 1'b1, 32'hDEAD_BEEF, 32'h0};
        vecs[9]  = '{2'd3, 1'b0, 32'h0,         32'h0};
        vecs[10] = '{2'd2, 1'b1, 32'h4,         32'h0};
        vecs[11] = '{2'd2, 1'b0, 32'h0,         32'h4};
        for (int i = 0; i < 12; i++) begin
            bus_req(vecs[i].addr, vecs[i].we, vecs[i].data, rd);
            if (!vecs[i].we) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
        end

        // Cycle-exact A5 frame at 4 clocks per bit.
        mon_bp = 4;
        rx_q.delete(); st_q.delete();
        a5 = 8'hA5;
        for (int i = 0; i < 40; i++) e[i] = (i < 4) ? 1'b0 : (i >= 36) ? 1'b1 : a5[i/4 - 1];
        bus_req(2'd0, 1'b1, 32'hFFFF_FFA5, rd);
        chk("a5_tx_pre", {31'd0, tx}, 32'd1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk($sformatf("a5_tx%0d", i), {31'd0, tx}, {31'd0, e[i]});
        end
        @(negedge clk);
        chk("a5_tx_post", {31'd0, tx}, 32'd1);
        chk("a5_rx", {24'd0, rx_q[0]}, 32'hA5);
        repeat (3) @(negedge clk);
        bus_req(2'd1, 1'b0, 32'h0, rd);
        chk("status_idle", rd, 32'h4);

        // Busy while a frame is on the wire.
        rx_q.delete(); st_q.delete();
        bus_req(2'd0, 1'b1, 32'h3C, rd);
        bus_req(2'd1, 1'b0, 32'h0, rd);
        chk("status_busy", rd, 32'h5);
        wait_rx(1, 100);
        chk("busy_rx", {24'd0, rx_q[0]}, 32'h3C);
        repeat (10) @(negedge clk);
        bus_req(2'd1, 1'b0, 32'h0, rd);
        chk("status_done", rd, 32'h4);

        // Six back-to-back pushes at 1 clock per bit: the sixth waits for the second pop.
        bus_req(2'd2, 1'b1, 32'h1, rd);
        mon_bp = 1;
        rx_q.delete(); st_q.delete();
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        k = 0; stall_cycles = 0;
        @(negedge clk);
        wb_addr = 2'd0; wb_we = 1'b1; wb_data_in = {24'd0, bytes[0]}; wb_stb = 1'b1; wb_cyc = 1'b1;
        for (int c = 0; c < 200 && k < 6; c++) begin
            acc = !wb_stall;
            if (!acc) stall_cycles++;
            @(posedge clk);
            #1;
            if (acc) begin
                k++;
                if (k < 6) wb_data_in = {24'd0, bytes[k]};
                else begin wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0; end
            end
            @(negedge clk);
            chk("burst_ack", {31'd0, wb_ack}, {31'd0, acc});
            chk("burst_rdata", wb_data_out, 32'h0);
        end
        chk("burst_pushed", k, 6);
        chk("burst_stalls", stall_cycles, 8);
        wait_rx(6, 200);
        for (int i = 0; i < 6 && i < rx_q.size(); i++)
            chk($sformatf("burst_rx%0d", i), {24'd0, rx_q[i]}, {24'd0, bytes[i]});
        for (int i = 1; i < 6 && i < st_q.size(); i++)
            chk($sformatf("burst_gap%0d", i), st_q[i] - st_q[i-1], 11);

        // Divider change mid-frame only affects the following frame.
        repeat (5) @(negedge clk);
        bus_req(2'd2, 1'b1, 32'h4, rd);
        mon_bp = 4;
        rx_q.delete(); st_q.delete();
        bus_req(2'd0, 1'b1, 32'h5A, rd);
        bus_req(2'd0, 1'b1, 32'hC3, rd);
        bus_req(2'd2, 1'b1, 32'h2, rd);
        mon_bp = 2;
        bus_req(2'd0, 1'b1, 32'h96, rd);
        wait_rx(3, 300);
        if (rx_q.size() >= 3) begin
            chk("baud_rx0", {24'd0, rx_q[0]}, 32'h5A);
            chk("baud_rx1", {24'd0, rx_q[1]}, 32'hC3);
            chk("baud_rx2", {24'd0, rx_q[2]}, 32'h96);
            chk("baud_frame_old", st_q[1] - st_q[0], 41);
            chk("baud_frame_new", st_q[2] - st_q[1], 21);
        end

        // Strobe without cycle and cycle without strobe are not requests.
        repeat (10) @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b0; wb_we = 1'b0; wb_addr = 2'd1;
        repeat (4) begin
            @(negedge clk);
            chk("nostb_ack", {31'd0, wb_ack}, 32'd0);
            chk("nostb_rdata", wb_data_out, 32'h0);
        end
        wb_cyc = 1'b0; wb_stb = 1'b1; wb_addr = 2'd2;
        repeat (4) begin
            @(negedge clk);
            chk("nocyc_ack", {31'd0, wb_ack}, 32'd0);
            chk("nocyc_rdata", wb_data_out, 32'h0);
        end
        wb_stb = 1'b0;

        // Reset in the middle of data bit 3.
        bus_req(2'd2, 1'b1, 32'h4, rd);
        mon_en = 1'b0;
        bus_req(2'd0, 1'b1, 32'h00, rd);
        for (int i = 0; i < 20 && tx !== 1'b0; i++) @(negedge clk);
        chk("rst_frame_start", {31'd0, tx}, 32'd0);
        repeat (17) @(negedge clk);
        chk("rst_mid_bit3", {31'd0, tx}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_tx_next", {31'd0, tx}, 32'd1);
        chk("rst_ack_drop", {31'd0, wb_ack}, 32'd0);
        reset = 1'b0;
        bus_req(2'd1, 1'b0, 32'h0, rd);
        chk("rst_status", rd, 32'h4);
        bus_req(2'd2, 1'b0, 32'h0, rd);
        chk("rst_baud_default", rd, 32'd434);
        lows = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        chk("rst_no_frame", lows, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
